// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte handshake for the shared UART transmitter.
// The arbiter takes the slave view; client logic (or a bench) drives the master view.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;

  modport master (output req_valid, output req_data, input  req_ready);
  modport slave  (input  req_valid, input  req_data, output req_ready);
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds one UART transmitter a byte at a time.
// Frame and inter-frame gap are timed by counting Baud_Tick pulses.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FRAME_BITS = 10,
  parameter int GAP_BITS   = 1,
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W = $clog2(FRAME_BITS*OVERSAMPLE+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Baud_Tick,
  uart_tx_arbiter_if.slave  req,
  output logic              tx_enable,
  output logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic [ID_W-1:0]   grant_id,
  output logic              frame_done
);
  localparam int SEND_TC = FRAME_BITS*OVERSAMPLE - 1;
  localparam int GAP_TC  = (GAP_BITS > 0) ? GAP_BITS*OVERSAMPLE - 1 : 0;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic               sel_any;
  logic [ID_W-1:0]    sel_id;
  logic [NUM_REQ-1:0] sel_oh;
  logic [DATA_W-1:0]  sel_data;
  logic               term_hit;
  int unsigned        idx;

  // grant_id doubles as the round-robin pointer: search starts just past it
  always_comb begin
    sel_any = 1'b0;
    sel_id  = grant_id;
    idx     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(grant_id) + k) % NUM_REQ;
      if (!sel_any && req.req_valid[idx]) begin
        sel_any = 1'b1;
        sel_id  = ID_W'(idx);
      end
    end
    sel_oh = '0;
    if (sel_any) sel_oh[sel_id] = 1'b1;
    sel_data = req.req_data[sel_id*DATA_W +: DATA_W];
  end

  assign term_hit = Baud_Tick &&
                    (((state == SEND) && (cnt == CNT_W'(SEND_TC))) ||
                     ((state == GAP)  && (cnt == CNT_W'(GAP_TC))));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (sel_any) state_nx = LOAD;
      LOAD:    state_nx = SEND;
      SEND:    if (term_hit) state_nx = (GAP_BITS > 0) ? GAP : IDLE;
      GAP:     if (term_hit) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req.req_ready = (state == IDLE) ? sel_oh : '0;
    tx_enable     = (state == LOAD);
    busy          = (state != IDLE);
  end

  // Counter restarts at zero on each terminal tick, so SEND and GAP share it
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      tx_data    <= '0;
      grant_id   <= ID_W'(NUM_REQ-1);
      frame_done <= 1'b0;
    end else begin
      if (((state == SEND) || (state == GAP)) && Baud_Tick)
        cnt <= term_hit ? '0 : cnt + CNT_W'(1);
      if ((state == IDLE) && sel_any) begin
        tx_data  <= sel_data;
        grant_id <= sel_id;
      end
      frame_done <= term_hit && (state_nx == IDLE);
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed plus randomized bench for uart_tx_arbiter; a second instance
// is built without an inter-frame gap.
module tb_uart_tx_arbiter;
  localparam int N = 4, W = 8, OS = 16, FB = 10, GB = 1;
  localparam int FRAME_TICKS = (FB+GB)*OS;
  localparam int ZFRAME_TICKS = FB*OS;

  logic clk = 1'b0, reset = 1'b1, tick = 1'b0, z_tick = 1'b0;
  logic tx_enable, busy, frame_done, z_en, z_busy, z_fd;
  logic [W-1:0] tx_data, z_data;
  logic [1:0] grant_id, z_gid;
  logic zv = 1'b0;
  int zphase = 0;
  int n_cmp = 0, n_bad = 0;
  int last_id = N-1;

  uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) rif();
  uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) zif();

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .OVERSAMPLE(OS), .FRAME_BITS(FB), .GAP_BITS(GB)) dut (
    .clk(clk), .reset(reset), .Baud_Tick(tick), .req(rif),
    .tx_enable(tx_enable), .tx_data(tx_data), .busy(busy), .grant_id(grant_id), .frame_done(frame_done));

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .OVERSAMPLE(OS), .FRAME_BITS(FB), .GAP_BITS(0)) dut_z (
    .clk(clk), .reset(reset), .Baud_Tick(z_tick), .req(zif),
    .tx_enable(z_en), .tx_data(z_data), .busy(z_busy), .grant_id(z_gid), .frame_done(z_fd));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the edge; outputs are sampled 1 ns later.
  task automatic cyc(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic t);
    @(posedge clk); #1;
    rif.req_valid = v; rif.req_data = d; tick = t;
    zif.req_valid = {{(N-1){1'b0}}, zv};
    z_tick = (zphase % 4) == 0; zphase++;
    #1;
  endtask

  function automatic int model_pick(input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) if (v[(last_id+k)%N]) return (last_id+k)%N;
    return -1;
  endfunction

  // Entered at the sample point of an accept cycle; leaves at the frame_done cycle.
  task automatic run_frame(input logic [N-1:0] v_acc, input logic [N-1:0] v_after,
                           input logic [N*W-1:0] d, input int pulse_bit);
    int win, nt, cycles;
    logic t;
    logic [N-1:0] exp_oh, vv;
    win = model_pick(v_acc);
    exp_oh = '0; exp_oh[win] = 1'b1;
    chk("accept_ready", rif.req_ready, exp_oh);
    chk("accept_busy", busy, 1'b0);
    last_id = win;
    cyc(v_after, d, 1'($urandom_range(0, 1)));
    chk("load_tx_enable", tx_enable, 1'b1);
    chk("load_tx_data", tx_data, d[win*W +: W]);
    chk("load_grant_id", grant_id, win);
    chk("load_busy", busy, 1'b1);
    nt = 0; cycles = 0;
    while (nt < FRAME_TICKS && cycles < 5000) begin
      t = ($urandom_range(0, 2) == 0);
      vv = v_after;
      if (cycles == 3 && pulse_bit >= 0) vv[pulse_bit] = 1'b1;
      cyc(vv, d, t);
      cycles++;
      if (t) nt++;
      chk("frame_busy_outs", {busy, frame_done, tx_enable, rif.req_ready}, {3'b100, {N{1'b0}}});
    end
    chk("frame_tick_budget", nt, FRAME_TICKS);
    cyc(v_after, d, 1'($urandom_range(0, 1)));
    chk("frame_done_pulse", {busy, frame_done}, 2'b01);
    chk("tx_data_hold", tx_data, d[win*W +: W]);
    if (v_after == '0) chk("idle_no_ready", rif.req_ready, '0);
  endtask

  initial begin
    logic [N*W-1:0] d;
    logic [N-1:0] v, v2;
    int nt, cycles;
    rif.req_valid = '0; rif.req_data = '0; zif.req_valid = '0; zif.req_data = '0;
    zif.req_data[7:0] = 8'h3C;
    d = '0;
    repeat (3) cyc('0, d, 1'b0);
    reset = 1'b0;
    cyc('0, d, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_grant_id", grant_id, N-1);
    chk("rst_outs", {busy, frame_done, tx_enable, rif.req_ready}, '0);

    // single request from requester 2
    d = '0; d[2*W +: W] = 8'hA5;
    cyc(4'b0100, d, 1'b0);
    run_frame(4'b0100, 4'b0000, d, -1);
    chk("t1_grant", grant_id, 2);

    // requester 0 served while requester 3 pulses valid for one busy cycle
    d = '0; d[0 +: W] = 8'h77; d[3*W +: W] = 8'hEE;
    cyc(4'b0001, d, 1'b0);
    run_frame(4'b0001, 4'b0000, d, 3);
    cyc('0, d, 1'b0);
    chk("withdraw_idle", {busy, rif.req_ready}, '0);
    chk("withdraw_grant", grant_id, 0);

    // all four valid after reset: order 0,1,2,3,0
    reset = 1'b1; cyc('0, d, 1'b0); reset = 1'b0; last_id = N-1;
    d = {8'h13, 8'h12, 8'h11, 8'h10};
    cyc(4'hF, d, 1'b0);
    for (int i = 0; i < 5; i++) begin
      run_frame(4'hF, (i < 4) ? 4'hF : 4'h0, d, -1);
      chk("rr_order", grant_id, (i < 4) ? i : 0);
    end

    // persistent single requester 1
    d = '0; d[1*W +: W] = 8'h5A;
    cyc(4'b0010, d, 1'b0);
    for (int i = 0; i < 3; i++) begin
      run_frame(4'b0010, (i < 2) ? 4'b0010 : 4'b0000, d, -1);
      chk("b2b_grant", grant_id, 1);
    end

    // reset in the middle of SEND
    d = '0; d[2*W +: W] = 8'hC3;
    cyc(4'b0100, d, 1'b0);
    chk("mid_accept", rif.req_ready, 4'b0100);
    cyc('0, d, 1'b0);
    chk("mid_load", tx_enable, 1'b1);
    nt = 0; cycles = 0;
    while (nt < 80 && cycles < 2000) begin
      cyc('0, d, 1'($urandom_range(0, 1)));
      cycles++;
      if (tick) nt++;
    end
    chk("mid_ticks", nt, 80);
    reset = 1'b1;
    cyc('0, d, 1'b1);
    chk("mid_rst_outs", {busy, tx_enable, frame_done}, 3'b000);
    chk("mid_rst_data", tx_data, 8'h00);
    chk("mid_rst_gid", grant_id, 3);
    reset = 1'b0; last_id = N-1;
    for (int i = 0; i < 300; i++) begin
      cyc('0, d, 1'($urandom_range(0, 1)));
      chk("mid_no_done", {busy, frame_done}, 2'b00);
    end
    d = '0; d[0 +: W] = 8'h81;
    cyc(4'b0001, d, 1'b0);
    run_frame(4'b0001, 4'b0000, d, -1);
    chk("post_rst_grant", grant_id, 0);

    // randomized request patterns with held data
    d = {$urandom, $urandom};
    v = 4'($urandom_range(1, 15));
    cyc(v, d, 1'b0);
    for (int i = 0; i < 4; i++) begin
      v2 = (i < 3) ? 4'($urandom_range(1, 15)) : 4'h0;
      run_frame(v, v2, d, -1);
      v = v2;
    end

    // no-gap build: frame_done after exactly FRAME_BITS*OVERSAMPLE ticks
    zv = 1'b1;
    cyc('0, d, 1'b0);
    chk("z_ready", zif.req_ready, 4'b0001);
    zv = 1'b0;
    cyc('0, d, 1'b0);
    chk("z_load", {z_en, z_data}, {1'b1, 8'h3C});
    nt = 0; cycles = 0;
    while (nt < ZFRAME_TICKS && cycles < 3000) begin
      cyc('0, d, 1'b0);
      cycles++;
      if (z_tick) nt++;
      chk("z_busy", {z_busy, z_fd}, 2'b10);
    end
    chk("z_tick_budget", nt, ZFRAME_TICKS);
    cyc('0, d, 1'b0);
    chk("z_done", {z_busy, z_fd}, 2'b01);
    cyc('0, d, 1'b0);
    chk("z_done_once", {z_busy, z_fd}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
